// File: rtl/avr109_uart_rx.sv
`timescale 1ns/1ps
// avr109_uart_rx: 8N1 UART receiver (LSB first, idle-high line).
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   rxd         asynchronous serial input
//   rx_enabled  allows new frames to start (only examined while idle)
//   rx_data     last good byte, held until the next good byte
//   rx_avail    one-cycle pulse, rx_data valid in the same cycle
//   rx_ferr     one-cycle pulse when the stop bit is sampled low
// Optional macro AVR109_UART_RX_MAJORITY_EN: each bit is a 2-of-3 vote of
// the line at mid-1/mid/mid+1, decided at mid+1.
module avr109_uart_rx #(
   parameter int unsigned CLK_FREQUENCY = 1000000,
   parameter int unsigned BAUD_RATE     = 19200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   input  logic       rx_enabled,
   output logic [7:0] rx_data,
   output logic       rx_avail,
   output logic       rx_ferr
);

   localparam int unsigned DIV   = CLK_FREQUENCY / BAUD_RATE;
   localparam int unsigned HALF  = DIV / 2;
   localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
`ifdef AVR109_UART_RX_MAJORITY_EN
   localparam int unsigned START_LOAD = HALF;
`else
   localparam int unsigned START_LOAD = HALF - 1;
`endif

   if (DIV < 8) begin : g_div_check
      $error("avr109_uart_rx: CLK_FREQUENCY/BAUD_RATE below 8 is unsupported");
   end

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

   state_t             state, state_nxt;
   logic [1:0]         sync_q;
   logic [1:0]         sync_ok;
   logic               line, line_d;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [2:0]         bit_cnt, bit_nxt;
   logic [7:0]         shift, shift_nxt;
   logic [7:0]         data_nxt;
   logic               avail_nxt, ferr_nxt;
   logic               fall, tick, sample;

   assign line = sync_q[1];
   assign fall = line_d & ~line;
   assign tick = (cnt == '0);

`ifdef AVR109_UART_RX_MAJORITY_EN
   logic line_d2;

   // Third vote tap: line two cycles back.
   always_ff @(posedge clk) begin
      if (rst) line_d2 <= 1'b1;
      else     line_d2 <= line_d;
   end

   assign sample = (line & line_d) | (line & line_d2) | (line_d & line_d2);
`else
   assign sample = line;
`endif

   // Synchronizer plus edge-detect history. line_d stays low until the
   // synchronizer holds a real rxd sample, so a line that is already low
   // when reset releases is never mistaken for a start edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= 2'b11;
         sync_ok <= 2'b00;
         line_d  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], rxd};
         sync_ok <= {sync_ok[0], 1'b1};
         line_d  <= sync_ok[1] ? line : 1'b0;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         bit_cnt  <= 3'd0;
         shift    <= 8'h00;
         rx_data  <= 8'h00;
         rx_avail <= 1'b0;
         rx_ferr  <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         bit_cnt  <= bit_nxt;
         shift    <= shift_nxt;
         rx_data  <= data_nxt;
         rx_avail <= avail_nxt;
         rx_ferr  <= ferr_nxt;
      end
   end

   // Next-state logic; the tick counter counts down and reloads on expiry.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      bit_nxt   = bit_cnt;
      shift_nxt = shift;
      data_nxt  = rx_data;
      avail_nxt = 1'b0;
      ferr_nxt  = 1'b0;
      unique case (state)
         IDLE: begin
            if (fall && rx_enabled) begin
               state_nxt = START;
               cnt_nxt   = CNT_W'(START_LOAD);
            end
         end
         START: begin
            if (tick) begin
               cnt_nxt = CNT_W'(DIV - 1);
               bit_nxt = 3'd0;
               if (sample) state_nxt = IDLE;
               else        state_nxt = DATA;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         DATA: begin
            if (tick) begin
               cnt_nxt   = CNT_W'(DIV - 1);
               shift_nxt = {sample, shift[7:1]};
               bit_nxt   = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) state_nxt = STOP;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         STOP: begin
            if (tick) begin
               cnt_nxt = CNT_W'(DIV - 1);
               if (sample) begin
                  data_nxt  = shift;
                  avail_nxt = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  ferr_nxt  = 1'b1;
                  state_nxt = WAIT_HIGH;
               end
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         WAIT_HIGH: begin
            if (line) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_avr109_uart_rx.sv
`timescale 1ns/1ps
// Self-checking bench for avr109_uart_rx: directed frames plus randomized
// traffic, expectations queued at frame issue and checked by a monitor.
module tb_avr109_uart_rx;

   localparam int unsigned CLK_FREQUENCY = 1000000;
   localparam int unsigned BAUD_RATE     = 19200;
   localparam int unsigned DIV           = CLK_FREQUENCY / BAUD_RATE;
   localparam int unsigned HALF          = DIV / 2;
`ifdef AVR109_UART_RX_MAJORITY_EN
   localparam longint LAT_NOM = 496;
`else
   localparam longint LAT_NOM = 495;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rxd = 1'b1;
   logic       rx_enabled = 1'b1;
   logic [7:0] rx_data;
   logic       rx_avail;
   logic       rx_ferr;

   avr109_uart_rx #(
      .CLK_FREQUENCY(CLK_FREQUENCY),
      .BAUD_RATE(BAUD_RATE)
   ) dut (
      .clk(clk),
      .rst(rst),
      .rxd(rxd),
      .rx_enabled(rx_enabled),
      .rx_data(rx_data),
      .rx_avail(rx_avail),
      .rx_ferr(rx_ferr)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       ferr;
      logic [7:0] data;
   } exp_t;

   exp_t       q[$];
   exp_t       e;
   int         total = 0;
   int         bad = 0;
   longint     cyc = 0;
   longint     last_fall_cyc = 0;
   longint     last_avail_cyc = 0;
   logic [7:0] model_last = 8'h00;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every output pulse cycle pops one expectation.
   always @(negedge clk) begin
      if (!rst && (rx_avail || rx_ferr)) begin
         total++;
         if (rx_avail) last_avail_cyc = cyc;
         if (rx_avail && rx_ferr) begin
            bad++;
            $display("FAIL both_pulses avail=1 ferr=1 data=%02h", rx_data);
         end else if (q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_output avail=%0d ferr=%0d data=%02h",
                     rx_avail, rx_ferr, rx_data);
         end else begin
            e = q.pop_front();
            if (e.ferr !== rx_ferr || e.data !== rx_data) begin
               bad++;
               $display("FAIL scoreboard got ferr=%0d data=%02h expected ferr=%0d data=%02h",
                        rx_ferr, rx_data, e.ferr, e.data);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Reference model: an accepted frame yields its byte on a good stop bit,
   // otherwise a framing error with the previous good byte still shown.
   task automatic expect_frame(input logic [7:0] b, input logic stop, input logic en);
      if (en) begin
         if (stop) begin
            q.push_back({1'b0, b});
            model_last = b;
         end else begin
            q.push_back({1'b1, model_last});
         end
      end
   endtask

   // Drives one 10-bit frame; optional 1-cycle glitch at mid of a data bit,
   // optional rx_enabled drop mid-frame. Called and returns at a negedge.
   task automatic send_frame(input logic [7:0] b, input logic stop,
                             input int glitch_bit, input logic en_drop);
      logic [9:0] fr;
      fr = {stop, b, 1'b0};
      last_fall_cyc = cyc;
      for (int j = 0; j < 10; j++) begin
         rxd = fr[j];
         if (glitch_bit >= 0 && j == glitch_bit + 1) begin
            idle(HALF);
            rxd = ~fr[j];
            idle(1);
            rxd = fr[j];
            idle(DIV - HALF - 1);
         end else begin
            idle(DIV);
         end
         if (en_drop && j == 4) rx_enabled = 1'b0;
      end
   endtask

   task automatic wait_drain(input int max_cycles);
      int n;
      n = 0;
      while (q.size() != 0 && n < max_cycles) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain pending=%0d expected=0", q.size());
      end
   endtask

   initial begin : watchdog
      repeat (95000) @(posedge clk);
      bad++;
      total++;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : main
      logic [9:0] fr;
      logic [7:0] b;
      logic       stop, en, drop;
      longint     lat;

      idle(5);
      check("reset_rx_data", 32'(rx_data), 32'h00);
      check("reset_rx_avail", 32'(rx_avail), 32'h0);
      check("reset_rx_ferr", 32'(rx_ferr), 32'h0);
      rst = 1'b0;
      idle(20);

      // Single frame and its latency.
      expect_frame(8'h1B, 1'b1, 1'b1);
      send_frame(8'h1B, 1'b1, -1, 1'b0);
      idle(DIV);
      wait_drain(300);
      lat = last_avail_cyc - last_fall_cyc - 1;
      total++;
      if (lat < LAT_NOM - 2 || lat > LAT_NOM + 2) begin
         bad++;
         $display("FAIL latency got=%0d expected=%0d+/-2", lat, LAT_NOM);
      end
      check("data_1B", 32'(rx_data), 32'h1B);

      // Back-to-back frames, no idle time.
      for (int i = 0; i < 6; i++) begin
         b = (i % 2 == 0) ? 8'h1B : 8'hAA;
         expect_frame(b, 1'b1, 1'b1);
         send_frame(b, 1'b1, -1, 1'b0);
      end
      idle(DIV);
      wait_drain(300);

      // Short low glitch is rejected, then a real frame.
      rxd = 1'b0;
      idle(10);
      rxd = 1'b1;
      idle(2 * DIV);
      expect_frame(8'h41, 1'b1, 1'b1);
      send_frame(8'h41, 1'b1, -1, 1'b0);
      idle(DIV);
      wait_drain(300);
      check("data_41", 32'(rx_data), 32'h41);

      // Framing error followed by a held break.
      expect_frame(8'h56, 1'b0, 1'b1);
      send_frame(8'h56, 1'b0, -1, 1'b0);
      idle(2000);
      check("data_after_break", 32'(rx_data), 32'h41);
      wait_drain(10);
      rxd = 1'b1;
      idle(DIV);
      expect_frame(8'h50, 1'b1, 1'b1);
      send_frame(8'h50, 1'b1, -1, 1'b0);
      idle(DIV);
      wait_drain(300);
      check("data_50", 32'(rx_data), 32'h50);

      // Reset in the middle of data bit 4, line held low across release.
      fr = {1'b1, 8'hC3, 1'b0};
      for (int j = 0; j < 6; j++) begin
         rxd = fr[j];
         idle((j < 5) ? DIV : HALF);
      end
      rst = 1'b1;
      rxd = 1'b0;
      idle(3);
      check("midreset_rx_data", 32'(rx_data), 32'h00);
      check("midreset_rx_avail", 32'(rx_avail), 32'h0);
      model_last = 8'h00;
      rst = 1'b0;
      idle(600);
      rxd = 1'b1;
      idle(DIV);
      check("after_reset_rx_data", 32'(rx_data), 32'h00);

      // Disabled at the start edge: frame ignored.
      rx_enabled = 1'b0;
      expect_frame(8'h5A, 1'b1, 1'b0);
      send_frame(8'h5A, 1'b1, -1, 1'b0);
      rx_enabled = 1'b1;
      idle(DIV);
      check("disabled_rx_data", 32'(rx_data), 32'h00);

`ifdef AVR109_UART_RX_MAJORITY_EN
      // Single-cycle glitch at mid of data bit 2 is outvoted.
      expect_frame(8'h74, 1'b1, 1'b1);
      send_frame(8'h74, 1'b1, 2, 1'b0);
      idle(DIV);
      wait_drain(300);
      check("majority_74", 32'(rx_data), 32'h74);
`endif

      // Randomized traffic.
      for (int i = 0; i < 40; i++) begin
         b    = 8'($urandom);
         stop = ($urandom % 6) != 0;
         en   = ($urandom % 8) != 0;
         drop = en && (($urandom % 4) == 0);
         rx_enabled = en;
         expect_frame(b, stop, en);
         send_frame(b, stop, -1, drop);
         rx_enabled = 1'b1;
         if (!stop) begin
            idle(int'($urandom_range(0, 100)));
            rxd = 1'b1;
            idle(DIV);
         end else if (($urandom % 2) == 0) begin
            idle(int'($urandom_range(1, 3 * DIV)));
         end
      end
      idle(DIV);
      wait_drain(600);
      check("final_rx_data", 32'(rx_data), 32'(model_last));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
